// File: rtl/mips_cpu_harvard.sv
`timescale 1ns/1ps
// Single-cycle Harvard MIPS-I subset core: fetch, decode, execute, memory and
//   writeback all complete in one enabled clk cycle.
// Latency: one instruction per enabled edge; register writes are visible to the
//   very next instruction.
// Backpressure: clk_enable=0 freezes every register and forces data_read and
//   data_write low.
// Ports: clk/reset (sync, active-high), clk_enable; instr_address/instr_readdata
//   form the instruction port; data_address/data_read/data_write/data_writedata/
//   data_readdata form the data port; active and register_v0 are status outputs.
module mips_cpu_harvard (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Architectural state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_regs [32];
  // A taken branch/jump does not redirect immediately: the delay-slot
  // instruction at PC+4 runs first, and the target waits here for one step.
  logic        r_slot_vld;
  logic [31:0] r_slot_tgt;

  // Decode fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;

  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus8;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_mem_addr;
  logic [31:0] w_next_pc;
  logic        w_go;

  // Execute results
  logic [31:0] w_result;
  logic        w_wr_en;
  logic [4:0]  w_wr_idx;
  logic        w_ctl;
  logic [31:0] w_ctl_tgt;
  logic        w_is_lw;
  logic        w_is_sw;

  assign w_op    = instr_readdata[31:26];
  assign w_rs    = instr_readdata[25:21];
  assign w_rt    = instr_readdata[20:16];
  assign w_rd    = instr_readdata[15:11];
  assign w_shamt = instr_readdata[10:6];
  assign w_funct = instr_readdata[5:0];
  assign w_imm   = instr_readdata[15:0];
  assign w_simm  = {{16{w_imm[15]}}, w_imm};
  assign w_zimm  = {16'h0000, w_imm};

  // $0 is hard-wired: never written, but guarded on read as well so a
  // stray value can never leak out of it.
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_plus8 = r_pc + 32'd8;
  assign w_br_tgt   = w_pc_plus4 + {w_simm[29:0], 2'b00};
  assign w_j_tgt    = {w_pc_plus4[31:28], instr_readdata[25:0], 2'b00};
  assign w_mem_addr = w_rs_val + w_simm;

  // Execute stage: produces the writeback value/destination and any
  // control transfer to be applied after the delay slot.
  always_comb begin
    w_result  = 32'd0;
    w_wr_en   = 1'b0;
    w_wr_idx  = 5'd0;
    w_ctl     = 1'b0;
    w_ctl_tgt = 32'd0;
    w_is_lw   = 1'b0;
    w_is_sw   = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        w_wr_idx = w_rd;
        w_wr_en  = 1'b1;
        case (w_funct)
          FN_ADDU: w_result = w_rs_val + w_rt_val;
          FN_SUBU: w_result = w_rs_val - w_rt_val;
          FN_AND:  w_result = w_rs_val & w_rt_val;
          FN_OR:   w_result = w_rs_val | w_rt_val;
          FN_XOR:  w_result = w_rs_val ^ w_rt_val;
          FN_SLT:  w_result = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
          FN_SLTU: w_result = {31'd0, w_rs_val < w_rt_val};
          FN_SLL:  w_result = w_rt_val << w_shamt;
          FN_SRL:  w_result = w_rt_val >> w_shamt;
          FN_SRA:  w_result = $signed(w_rt_val) >>> w_shamt;
          FN_JR: begin
            w_wr_en   = 1'b0;
            w_ctl     = 1'b1;
            w_ctl_tgt = w_rs_val;
          end
          FN_JALR: begin
            w_result  = w_pc_plus8;
            w_ctl     = 1'b1;
            w_ctl_tgt = w_rs_val;
          end
          default: w_wr_en = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        w_wr_en = 1'b1; w_wr_idx = w_rt; w_result = w_rs_val + w_simm;
      end
      OP_SLTI: begin
        w_wr_en = 1'b1; w_wr_idx = w_rt;
        w_result = {31'd0, $signed(w_rs_val) < $signed(w_simm)};
      end
      OP_SLTIU: begin
        w_wr_en = 1'b1; w_wr_idx = w_rt;
        w_result = {31'd0, w_rs_val < w_simm};
      end
      OP_ANDI: begin
        w_wr_en = 1'b1; w_wr_idx = w_rt; w_result = w_rs_val & w_zimm;
      end
      OP_ORI: begin
        w_wr_en = 1'b1; w_wr_idx = w_rt; w_result = w_rs_val | w_zimm;
      end
      OP_XORI: begin
        w_wr_en = 1'b1; w_wr_idx = w_rt; w_result = w_rs_val ^ w_zimm;
      end
      OP_LUI: begin
        w_wr_en = 1'b1; w_wr_idx = w_rt; w_result = {w_imm, 16'h0000};
      end
      OP_LW: begin
        w_is_lw = 1'b1; w_wr_en = 1'b1; w_wr_idx = w_rt; w_result = data_readdata;
      end
      OP_SW: w_is_sw = 1'b1;
      OP_BEQ: begin
        w_ctl     = (w_rs_val == w_rt_val);
        w_ctl_tgt = w_br_tgt;
      end
      OP_BNE: begin
        w_ctl     = (w_rs_val != w_rt_val);
        w_ctl_tgt = w_br_tgt;
      end
      OP_J: begin
        w_ctl = 1'b1; w_ctl_tgt = w_j_tgt;
      end
      OP_JAL: begin
        w_ctl = 1'b1; w_ctl_tgt = w_j_tgt;
        w_wr_en = 1'b1; w_wr_idx = 5'd31; w_result = w_pc_plus8;
      end
      default: ;  // unsupported opcode behaves as NOP
    endcase
  end

  // The instruction now executing is a delay slot when a transfer is pending.
  assign w_next_pc = r_slot_vld ? r_slot_tgt : w_pc_plus4;
  assign w_go      = clk_enable && (r_state == ST_RUN);

  // Run/halt FSM: halting happens on the edge where the PC would become 0.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (clk_enable && (w_next_pc == 32'd0)) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_slot_vld <= 1'b0;
      r_slot_tgt <= 32'd0;
    end else if (w_go) begin
      r_pc       <= w_next_pc;
      r_slot_vld <= w_ctl;
      r_slot_tgt <= w_ctl_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_go && w_wr_en && (w_wr_idx != 5'd0)) begin
      r_regs[w_wr_idx] <= w_result;
    end
  end

  assign active         = (r_state == ST_RUN);
  assign register_v0    = r_regs[2];
  assign instr_address  = r_pc;
  assign data_address   = w_mem_addr;
  assign data_read      = w_go && w_is_lw;
  assign data_write     = w_go && w_is_sw;
  assign data_writedata = data_write ? w_rt_val : 32'd0;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
`timescale 1ns/1ps
// Bench for mips_cpu_harvard: directed and random programs, an ISA-level
// interpreter producing the expected per-step trace, and a negedge monitor
// that scores the DUT against that trace.
module tb_mips_cpu_harvard;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] FILL_INS = 32'hAC02_0000;  // sw $2,0($0) outside the program

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  mips_cpu_harvard dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .register_v0(register_v0), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .data_address(data_address),
    .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  // Memories
  logic [31:0] imem [64];
  logic [31:0] mem_init [1024];
  logic [31:0] dmem [1024];
  logic [31:0] ioff;

  assign ioff           = instr_address - RESET_PC;
  assign instr_readdata = (ioff < 32'd256 && ioff[1:0] == 2'b00) ? imem[ioff[7:2]] : FILL_INS;
  assign data_readdata  = dmem[data_address[11:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= mem_init[i];
    end else if (data_write) begin
      dmem[data_address[11:2]] <= data_writedata;
    end
  end

  // Scoreboard
  typedef struct {
    bit          halt;
    logic [31:0] pc;
    logic [31:0] v0;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } step_t;

  step_t       exp_q [$];
  step_t       h;
  bit          mon_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mr [32];
  logic [31:0] mm [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem_at(input logic [31:0] a);
    logic [31:0] off;
    off = a - RESET_PC;
    if (off < 32'd256 && off[1:0] == 2'b00) return imem[off[7:2]];
    return FILL_INS;
  endfunction

  // ISA interpreter: classic pc/next-pc pair gives the delay slot for free.
  task automatic model_run(input int cap);
    logic [31:0] pc, npc, nnpc, ins, a, b, res, simm, zimm, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    int          dst;
    step_t       s;
    for (int i = 0; i < 32; i++) mr[i] = 32'd0;
    for (int i = 0; i < 1024; i++) mm[i] = mem_init[i];
    pc  = RESET_PC;
    npc = pc + 32'd4;
    for (int n = 0; n < cap; n++) begin
      ins  = imem_at(pc);
      op   = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
      rd   = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'h0, ins[15:0]};
      a    = mr[rs];
      b    = mr[rt];
      ea   = a + simm;
      nnpc = npc + 32'd4;
      dst  = 0;
      res  = 32'd0;
      s.halt = 0; s.pc = pc; s.v0 = mr[2]; s.wr = 0; s.rd = 0; s.addr = 0; s.wdata = 0;
      case (op)
        6'h00: case (fn)
          6'h21: begin dst = rd; res = a + b; end
          6'h23: begin dst = rd; res = a - b; end
          6'h24: begin dst = rd; res = a & b; end
          6'h25: begin dst = rd; res = a | b; end
          6'h26: begin dst = rd; res = a ^ b; end
          6'h2A: begin dst = rd; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'h2B: begin dst = rd; res = (a < b) ? 32'd1 : 32'd0; end
          6'h00: begin dst = rd; res = b << sh; end
          6'h02: begin dst = rd; res = b >> sh; end
          6'h03: begin dst = rd; res = $signed(b) >>> sh; end
          6'h08: nnpc = a;
          6'h09: begin nnpc = a; dst = rd; res = pc + 32'd8; end
          default: ;
        endcase
        6'h09: begin dst = rt; res = a + simm; end
        6'h0A: begin dst = rt; res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
        6'h0B: begin dst = rt; res = (a < simm) ? 32'd1 : 32'd0; end
        6'h0C: begin dst = rt; res = a & zimm; end
        6'h0D: begin dst = rt; res = a | zimm; end
        6'h0E: begin dst = rt; res = a ^ zimm; end
        6'h0F: begin dst = rt; res = {ins[15:0], 16'h0}; end
        6'h23: begin dst = rt; res = mm[ea[11:2]]; s.rd = 1; s.addr = ea; end
        6'h2B: begin s.wr = 1; s.addr = ea; s.wdata = b; mm[ea[11:2]] = b; end
        6'h04: if (a == b) nnpc = npc + (simm << 2);
        6'h05: if (a != b) nnpc = npc + (simm << 2);
        6'h02: nnpc = {npc[31:28], ins[25:0], 2'b00};
        6'h03: begin nnpc = {npc[31:28], ins[25:0], 2'b00}; dst = 31; res = pc + 32'd8; end
        default: ;
      endcase
      exp_q.push_back(s);
      if (dst != 0) mr[dst] = res;
      pc  = npc;
      npc = nnpc;
      if (pc == 32'd0) begin
        s.halt = 1; s.v0 = mr[2]; s.wr = 0; s.rd = 0;
        repeat (3) exp_q.push_back(s);
        return;
      end
    end
  endtask

  // Monitor: compares against the head of the expected trace each cycle,
  // consuming it only when the core is allowed to step.
  always @(negedge clk) begin
    if (!reset && mon_en && exp_q.size() > 0) begin
      h = exp_q[0];
      if (h.halt) begin
        chk("halt_active", 32'(active), 32'd0);
        chk("halt_v0", register_v0, h.v0);
        chk("halt_dwrite", 32'(data_write), 32'd0);
        chk("halt_dread", 32'(data_read), 32'd0);
        void'(exp_q.pop_front());
      end else begin
        chk("active", 32'(active), 32'd1);
        chk("pc", instr_address, h.pc);
        chk("v0", register_v0, h.v0);
        if (clk_enable) begin
          chk("dwrite", 32'(data_write), 32'(h.wr));
          chk("dread", 32'(data_read), 32'(h.rd));
          if (h.wr || h.rd) chk("daddr", data_address, h.addr);
          chk("wdata", data_writedata, h.wdata);
          void'(exp_q.pop_front());
        end else begin
          chk("stall_dwrite", 32'(data_write), 32'd0);
          chk("stall_dread", 32'(data_read), 32'd0);
        end
      end
    end
  end

  // Encoders
  function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_ins(input int op, input int idx);
    logic [31:0] t;
    t = RESET_PC + 32'(idx * 4);
    return {6'(op), t[27:2]};
  endfunction

  function automatic int rnd_dst();
    int d;
    d = int'($urandom_range(1, 15));
    if (d == 4) d = 2;
    if (d == 1) d = 3;
    return d;
  endfunction

  function automatic logic [31:0] rand_plain();
    int k, s1, s2;
    int fns [10] = '{'h21, 'h23, 'h24, 'h25, 'h26, 'h2A, 'h2B, 'h00, 'h02, 'h03};
    int ops [7]  = '{'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F};
    int bad [3]  = '{'h20, 'h1C, 'h28};
    k  = int'($urandom_range(0, 9));
    s1 = int'($urandom_range(0, 15));
    s2 = int'($urandom_range(0, 15));
    case (k)
      0, 1, 2: return r_ins(fns[$urandom_range(0, 9)], s1, s2, rnd_dst(), int'($urandom_range(0, 31)));
      3, 4, 5: return i_ins(ops[$urandom_range(0, 6)], s1, rnd_dst(), int'($urandom_range(0, 65535)));
      6:       return i_ins('h23, ($urandom_range(0, 1) != 0) ? 4 : 0, rnd_dst(), 4 * int'($urandom_range(0, 255)));
      7:       return i_ins('h2B, ($urandom_range(0, 1) != 0) ? 4 : 0, s2, 4 * int'($urandom_range(0, 255)));
      8:       return i_ins(bad[$urandom_range(0, 2)], s1, rnd_dst(), int'($urandom_range(0, 65535)));
      default: return r_ins('h18, s1, s2, rnd_dst(), 0);
    endcase
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    for (int i = 0; i < 1024; i++) mem_init[i] = $urandom;
  endtask

  // Forward-only control flow so every random program reaches JR $0.
  task automatic gen_random();
    int last, i, t;
    clear_mem();
    last = 1 + int'($urandom_range(8, 30));
    imem[0] = i_ins('h09, 0, 4, 'h100);
    i = 1;
    while (i < last) begin
      if (i + 1 < last && $urandom_range(0, 4) == 0) begin
        t = int'($urandom_range(i + 2, last));
        case ($urandom_range(0, 3))
          0: imem[i] = i_ins('h04, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), t - (i + 1));
          1: imem[i] = i_ins('h05, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), t - (i + 1));
          2: imem[i] = j_ins('h02, t);
          default: imem[i] = j_ins('h03, t);
        endcase
        imem[i + 1] = rand_plain();
        i += 2;
      end else begin
        imem[i] = rand_plain();
        i++;
      end
    end
    imem[last]     = r_ins('h08, 0, 0, 0, 0);
    imem[last + 1] = 32'd0;
  endtask

  task automatic load_directed(input int id);
    clear_mem();
    case (id)
      0: begin
        imem[0] = i_ins('h09, 0, 2, 5);
        imem[1] = r_ins('h08, 0, 0, 0, 0);
      end
      1: begin
        imem[0] = i_ins('h0F, 0, 3, 'h1234);
        imem[1] = i_ins('h0D, 3, 3, 'h5678);
        imem[2] = i_ins('h2B, 4, 3, 0);
        imem[3] = i_ins('h23, 4, 2, 0);
        imem[4] = r_ins('h08, 0, 0, 0, 0);
      end
      2: begin
        imem[0] = i_ins('h09, 0, 2, 1);
        imem[1] = i_ins('h04, 0, 0, 2);
        imem[2] = i_ins('h09, 2, 2, 1);
        imem[3] = i_ins('h09, 2, 2, 100);
        imem[4] = r_ins('h08, 0, 0, 0, 0);
      end
      3: begin
        imem[0]  = i_ins('h09, 0, 2, 'hFFFF);
        imem[1]  = r_ins('h2B, 0, 2, 2, 0);
        imem[2]  = i_ins('h09, 0, 2, 'hFFFF);
        imem[3]  = r_ins('h2A, 2, 0, 2, 0);
        imem[4]  = i_ins('h0F, 0, 3, 'h8000);
        imem[5]  = r_ins('h03, 0, 3, 2, 4);
        imem[6]  = r_ins('h02, 0, 3, 2, 4);
        imem[7]  = i_ins('h09, 0, 3, 'hFFFF);
        imem[8]  = i_ins('h09, 0, 5, 1);
        imem[9]  = r_ins('h21, 3, 5, 2, 0);
        imem[10] = r_ins('h08, 0, 0, 0, 0);
      end
      4: begin
        imem[0]  = j_ins('h03, 9);
        imem[1]  = i_ins('h09, 0, 2, 7);
        imem[2]  = i_ins('h09, 2, 2, 3);
        imem[3]  = i_ins('h0F, 0, 6, 'hBFC0);
        imem[4]  = i_ins('h0D, 6, 6, 'h2C);
        imem[5]  = r_ins('h09, 6, 0, 7, 0);
        imem[6]  = i_ins('h09, 2, 2, 1);
        imem[7]  = r_ins('h08, 0, 0, 0, 0);
        imem[9]  = r_ins('h08, 31, 0, 0, 0);
        imem[10] = i_ins('h09, 2, 2, 10);
        imem[11] = r_ins('h21, 2, 7, 2, 0);
        imem[12] = r_ins('h08, 7, 0, 0, 0);
      end
      default: begin  // endless loop: $2++ ; beq back ; nop
        imem[0] = i_ins('h09, 2, 2, 1);
        imem[1] = i_ins('h04, 0, 0, 'hFFFE);
      end
    endcase
  endtask

  // mode 0: always enabled; 1: random enable gaps; 2: 5-cycle hold early on
  task automatic run_prog(input int mode);
    int cyc;
    @(posedge clk); #1;
    reset      = 1'b1;
    clk_enable = ($urandom_range(0, 1) != 0);
    mon_en     = 1'b0;
    exp_q.delete();
    model_run(200);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    cyc    = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      case (mode)
        1:       clk_enable = ($urandom_range(0, 3) != 0);
        2:       clk_enable = !(cyc >= 1 && cyc <= 5);
        default: clk_enable = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() > 0) chk("timeout_pending_steps", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_loop_reset();
    load_directed(5);
    @(posedge clk); #1;
    reset = 1'b1; clk_enable = 1'b1; mon_en = 1'b0;
    exp_q.delete();
    model_run(400);
    @(posedge clk); #1;
    reset = 1'b0; mon_en = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
    end
    // Mid-loop reset with clk_enable low: must still take effect.
    reset = 1'b1; clk_enable = 1'b0; mon_en = 1'b0;
    exp_q.delete();
    model_run(400);
    @(posedge clk); #1;
    reset = 1'b0; clk_enable = 1'b1; mon_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    for (int id = 0; id < 5; id++) begin
      load_directed(id);
      run_prog(0);
    end
    load_directed(4);
    run_prog(2);
    load_directed(1);
    run_prog(2);
    run_loop_reset();
    for (int r = 0; r < 40; r++) begin
      gen_random();
      run_prog(r % 2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_harvard.md
MIPS_CPU_HARVARD -- requirements
Module: mips_cpu_harvard

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 clk_enable  input  1  high = execute one instruction per clk edge; low = hold all state and outputs.
REQ-005 active  output  1  high while running; low after halt.
REQ-006 register_v0  output  32  live value of GPR $2.
REQ-007 instr_address  output  32  byte address of the current instruction (PC), combinational from PC.
REQ-008 instr_readdata  input  32  instruction word at instr_address, valid in the same cycle.
REQ-009 data_address  output  32  byte address for lw/sw (rs + sign-extended imm16).
REQ-010 data_write  output  1  high during sw only; memory writes data_writedata at the clk edge.
REQ-011 data_read  output  1  high during lw only.
REQ-012 data_writedata  output  32  rt value during sw; 0 otherwise.
REQ-013 data_readdata  input  32  combinational read data, valid in the same cycle as data_read.

Function
REQ-014 Single-cycle Harvard core: fetch, decode, execute, memory and writeback complete within one enabled clk cycle.
REQ-015 32 x 32-bit register file; $0 reads 0 and ignores writes; reads combinational, write on clk edge.
REQ-016 R-type instructions: ADDU, SUBU, AND, OR, XOR, SLT (signed), SLTU (unsigned), SLL, SRL, SRA (shamt), JR, JALR.
REQ-017 I-type instructions: ADDIU, ANDI/ORI/XORI (zero-extend imm), SLTI/SLTIU (sign-extend imm), LUI, LW, SW, BEQ, BNE.
REQ-018 J-type instructions: J, JAL (target = {PC+4[31:28], imm26, 2'b00}).
REQ-019 Arithmetic SHALL be 32-bit modulo 2^32; no overflow traps.
REQ-020 Branch target = PC+4 + (sign-extended imm16 << 2); jumps and taken branches have one architectural delay slot: the instruction at PC+4 always executes before control transfers.
REQ-021 JAL/JALR write PC+8 to $31 (JALR: to rd).
REQ-022 Unsupported opcodes SHALL execute as NOP (PC advances, no register or memory write).
REQ-023 Halt: when the PC would become 0x00000000 (e.g. JR $0 after its delay slot), active SHALL go low at that edge; thereafter no register, PC or memory updates occur and data_write/data_read stay 0.
REQ-024 data_read and data_write SHALL never both be high; both are 0 when active=0 or clk_enable=0.
REQ-025 LW address and SW address are word-aligned by program contract; low two bits are passed through unmodified.
REQ-026 A register written by an instruction SHALL be visible to the next instruction (no hazards, single cycle).

Reset
REQ-027 At a clk edge with reset=1 (regardless of clk_enable): PC = 0xBFC00000, all GPRs = 0, pending delay-slot target cleared, active = 1.
REQ-028 After reset: register_v0 = 0, instr_address = 0xBFC00000, data_write = 0, data_read = 0.
REQ-029 Reset asserted mid-program SHALL abandon any pending branch/jump and restart at 0xBFC00000; reset also restarts a halted core.
REQ-030 active SHALL read 1 on the first edge after reset deasserts.

Verification
REQ-031 ADDIU $2,$0,5; JR $0; NOP -> active=1 after reset, then active=0 within 3 cycles, register_v0 = 5.
REQ-032 LUI $3,0x1234; ORI $3,$3,0x5678; SW $3,0($4); LW $2,0($4); JR $0; NOP -> one cycle with data_write=1, data_writedata=0x12345678; register_v0 = 0x12345678 at halt.
REQ-033 ADDIU $2,$0,1; BEQ $0,$0,+2; ADDIU $2,$2,1 (delay slot); ADDIU $2,$2,100 (skipped); JR $0; NOP -> register_v0 = 2.
REQ-034 ADDIU $2,$0,-1; SLTU $2,$0,$2 -> register_v0 = 1; SLT $2,$2,$0 with $2=0xFFFFFFFF -> 1; ADDU of 0xFFFFFFFF + 1 -> 0, no trap.
REQ-035 Assert reset for one cycle midway through a loop -> instr_address = 0xBFC00000 next cycle, register_v0 = 0, active = 1.
REQ-036 Hold clk_enable=0 for 5 cycles mid-program -> instr_address, register_v0, active unchanged and data_write=0 throughout; program resumes correctly when re-enabled.
